// File: rtl/la_mon_pkg.sv
// Shared types for the LA checkpoint monitor: controller states and the
// diagnostic codes reported on fail_code.
package la_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_PASS  = 2'd2,
        ST_FAIL  = 2'd3
    } state_t;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_TIMEOUT = 2'd1;
    localparam logic [1:0] FC_ORDER   = 2'd2;

endpackage

// File: rtl/la_stable_filter.sv
// Synchronizes the asynchronous status bus and emits one accept pulse per
// value once it has been seen unchanged for STABLE_CYCLES samples.
module la_stable_filter #(
    parameter int WIDTH         = 16,
    parameter int STABLE_CYCLES = 2
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic [WIDTH-1:0] i_bus,
    output logic             o_accept,
    output logic [WIDTH-1:0] o_value
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_val;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_changed;

    assign w_changed = (r_s2 != r_val);

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_changed)
            w_cnt_nxt = CW'(1);
        else if (r_cnt != CW'(STABLE_CYCLES))
            w_cnt_nxt = r_cnt + CW'(1);
    end

    // Pulse on the sample that brings the count to its limit, so the
    // controller acts on the same edge the count saturates.
    assign o_accept = (w_cnt_nxt == CW'(STABLE_CYCLES)) &&
                      (w_changed || (r_cnt != CW'(STABLE_CYCLES)));
    assign o_value  = r_s2;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_s1  <= '0;
            r_s2  <= '0;
            r_val <= '0;
            r_cnt <= '0;
        end else begin
            r_s1  <= i_bus;
            r_s2  <= r_s1;
            r_val <= r_s2;
            r_cnt <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/la_checkpoint_monitor.sv
// Matches an ordered, programmable sequence of checkpoint values seen on a
// firmware-driven status bus, with per-stage timeout and pass/fail report.
module la_checkpoint_monitor
    import la_mon_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int DEPTH         = 4,
    parameter int TIMEOUT_W     = 24,
    parameter int STABLE_CYCLES = 2
) (
    input  logic                         clock,
    input  logic                         resetb,
    input  logic [WIDTH-1:0]             mon_bus,
    input  logic                         cfg_we,
    input  logic [$clog2(DEPTH)-1:0]     cfg_addr,
    input  logic [WIDTH-1:0]             cfg_data,
    input  logic [$clog2(DEPTH+1)-1:0]   num_stages,
    input  logic [TIMEOUT_W-1:0]         timeout_limit,
    input  logic                         strict,
    input  logic                         start,
    output logic                         busy,
    output logic                         pass,
    output logic                         fail,
    output logic [1:0]                   fail_code,
    output logic [$clog2(DEPTH+1)-1:0]   stage_idx,
    output logic                         stage_strobe
);

    localparam int SW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]     r_exp [DEPTH];
    state_t               r_state,  w_state_nxt;
    logic [SW-1:0]        r_stage,  w_stage_nxt;
    logic [SW-1:0]        r_num,    w_num_nxt;
    logic [TIMEOUT_W-1:0] r_tcnt,   w_tcnt_nxt;
    logic [TIMEOUT_W-1:0] r_limit,  w_limit_nxt;
    logic                 r_strict, w_strict_nxt;
    logic                 r_pass,   w_pass_nxt;
    logic                 r_fail,   w_fail_nxt;
    logic [1:0]           r_code,   w_code_nxt;
    logic                 r_strobe, w_strobe_nxt;
    logic                 w_acc;
    logic [WIDTH-1:0]     w_acc_val;
    logic                 w_in_order;
    logic                 w_out_order;
    logic                 w_tmo;

    la_stable_filter #(
        .WIDTH         (WIDTH),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clock    (clock),
        .resetb   (resetb),
        .i_bus    (mon_bus),
        .o_accept (w_acc),
        .o_value  (w_acc_val)
    );

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < DEPTH; i++) r_exp[i] <= '0;
        end else if (cfg_we && (r_state != ST_ARMED) && (int'(cfg_addr) < DEPTH)) begin
            r_exp[cfg_addr] <= cfg_data;
        end
    end

    // Duplicate values in the table resolve to the in-order match first.
    always_comb begin
        w_in_order  = 1'b0;
        w_out_order = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            if (w_acc && (r_exp[j] == w_acc_val)) begin
                if (SW'(j) == r_stage)
                    w_in_order = 1'b1;
                else if ((SW'(j) > r_stage) && (SW'(j) < r_num))
                    w_out_order = 1'b1;
            end
        end
    end

    assign w_tmo = (r_limit != '0) && (r_tcnt == r_limit - TIMEOUT_W'(1));

    always_comb begin
        w_state_nxt  = r_state;
        w_stage_nxt  = r_stage;
        w_num_nxt    = r_num;
        w_tcnt_nxt   = r_tcnt;
        w_limit_nxt  = r_limit;
        w_strict_nxt = r_strict;
        w_pass_nxt   = r_pass;
        w_fail_nxt   = r_fail;
        w_code_nxt   = r_code;
        w_strobe_nxt = 1'b0;
        case (r_state)
            ST_ARMED: begin
                if (w_in_order) begin
                    w_stage_nxt  = r_stage + SW'(1);
                    w_strobe_nxt = 1'b1;
                    w_tcnt_nxt   = '0;
                    if (r_stage + SW'(1) == r_num) begin
                        w_state_nxt = ST_PASS;
                        w_pass_nxt  = 1'b1;
                    end
                end else if (w_out_order && r_strict) begin
                    w_state_nxt = ST_FAIL;
                    w_fail_nxt  = 1'b1;
                    w_code_nxt  = FC_ORDER;
                end else if (w_tmo) begin
                    w_state_nxt = ST_FAIL;
                    w_fail_nxt  = 1'b1;
                    w_code_nxt  = FC_TIMEOUT;
                end else if (r_limit != '0) begin
                    w_tcnt_nxt = r_tcnt + TIMEOUT_W'(1);
                end
            end
            default: begin
                if (start) begin
                    w_pass_nxt   = 1'b0;
                    w_fail_nxt   = 1'b0;
                    w_code_nxt   = FC_NONE;
                    w_stage_nxt  = '0;
                    w_tcnt_nxt   = '0;
                    w_num_nxt    = num_stages;
                    w_limit_nxt  = timeout_limit;
                    w_strict_nxt = strict;
                    if (num_stages == '0) begin
                        w_state_nxt = ST_PASS;
                        w_pass_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_ARMED;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_state  <= ST_IDLE;
            r_stage  <= '0;
            r_num    <= '0;
            r_tcnt   <= '0;
            r_limit  <= '0;
            r_strict <= 1'b0;
            r_pass   <= 1'b0;
            r_fail   <= 1'b0;
            r_code   <= FC_NONE;
            r_strobe <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_stage  <= w_stage_nxt;
            r_num    <= w_num_nxt;
            r_tcnt   <= w_tcnt_nxt;
            r_limit  <= w_limit_nxt;
            r_strict <= w_strict_nxt;
            r_pass   <= w_pass_nxt;
            r_fail   <= w_fail_nxt;
            r_code   <= w_code_nxt;
            r_strobe <= w_strobe_nxt;
        end
    end

    assign busy         = (r_state == ST_ARMED);
    assign pass         = r_pass;
    assign fail         = r_fail;
    assign fail_code    = r_code;
    assign stage_idx    = r_stage;
    assign stage_strobe = r_strobe;

endmodule

// File: tb/tb_la_checkpoint_monitor.sv
// Directed bench for la_checkpoint_monitor: sequencing, glitch filtering,
// timeout, ordering, configuration corner cases and mid-run reset.
module tb_la_checkpoint_monitor;

    logic        clock = 1'b0;
    logic        resetb;
    logic [15:0] mon_bus;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic [2:0]  num_stages;
    logic [23:0] timeout_limit;
    logic        strict;
    logic        start;
    logic        busy;
    logic        pass;
    logic        fail;
    logic [1:0]  fail_code;
    logic [2:0]  stage_idx;
    logic        stage_strobe;

    int n_checks = 0;
    int n_fail   = 0;

    la_checkpoint_monitor #(
        .WIDTH         (16),
        .DEPTH         (4),
        .TIMEOUT_W     (24),
        .STABLE_CYCLES (2)
    ) dut (
        .clock         (clock),
        .resetb        (resetb),
        .mon_bus       (mon_bus),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_data      (cfg_data),
        .num_stages    (num_stages),
        .timeout_limit (timeout_limit),
        .strict        (strict),
        .start         (start),
        .busy          (busy),
        .pass          (pass),
        .fail          (fail),
        .fail_code     (fail_code),
        .stage_idx     (stage_idx),
        .stage_strobe  (stage_strobe)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick(1);
        cfg_we   = 1'b0;
    endtask

    task automatic do_start(input logic [2:0] n, input logic [23:0] lim, input logic s);
        num_stages    = n;
        timeout_limit = lim;
        strict        = s;
        start         = 1'b1;
        tick(1);
        start         = 1'b0;
    endtask

    initial begin
        resetb = 1'b0; mon_bus = 16'h0000; cfg_we = 1'b0; cfg_addr = 2'd0;
        cfg_data = 16'h0000; num_stages = 3'd0; timeout_limit = 24'd0;
        strict = 1'b0; start = 1'b0;

        // Reset state
        tick(2);
        check("rst_busy",   32'(busy), 0);
        check("rst_pass",   32'(pass), 0);
        check("rst_fail",   32'(fail), 0);
        check("rst_code",   32'(fail_code), 0);
        check("rst_stage",  32'(stage_idx), 0);
        check("rst_strobe", 32'(stage_strobe), 0);
        resetb = 1'b1;
        tick(4);

        cfg_write(2'd0, 16'hAB60);
        cfg_write(2'd1, 16'hAB61);
        cfg_write(2'd2, 16'hAB62);
        cfg_write(2'd3, 16'hAB63);

        // Basic two-stage pass
        do_start(3'd2, 24'd0, 1'b0);
        check("basic_busy", 32'(busy), 1);
        mon_bus = 16'hAB60;
        tick(4);
        check("basic_s1_stage",  32'(stage_idx), 1);
        check("basic_s1_strobe", 32'(stage_strobe), 1);
        tick(1);
        check("basic_s1_strobe_off", 32'(stage_strobe), 0);
        mon_bus = 16'hAB61;
        tick(4);
        check("basic_s2_stage",  32'(stage_idx), 2);
        check("basic_s2_strobe", 32'(stage_strobe), 1);
        check("basic_pass",      32'(pass), 1);
        check("basic_busy_off",  32'(busy), 0);
        tick(1);
        check("basic_fail", 32'(fail), 0);
        check("basic_code", 32'(fail_code), 0);
        check("basic_pass_hold", 32'(pass), 1);

        // Glitch rejection, then exact latency
        mon_bus = 16'h0000;
        tick(5);
        do_start(3'd2, 24'd0, 1'b0);
        mon_bus = 16'hAB60;
        tick(1);
        mon_bus = 16'h0000;
        tick(6);
        check("glitch_stage",  32'(stage_idx), 0);
        check("glitch_strobe", 32'(stage_strobe), 0);
        mon_bus = 16'hAB60;
        tick(3);
        check("lat_stage_early", 32'(stage_idx), 0);
        tick(1);
        check("lat_stage", 32'(stage_idx), 1);

        // start and cfg_we while ARMED are dropped
        do_start(3'd0, 24'd0, 1'b0);
        check("armed_start_stage", 32'(stage_idx), 1);
        check("armed_start_busy",  32'(busy), 1);
        check("armed_start_pass",  32'(pass), 0);
        cfg_write(2'd1, 16'h1234);
        mon_bus = 16'hAB61;
        tick(4);
        check("busy_cfg_stage", 32'(stage_idx), 2);
        check("busy_cfg_pass",  32'(pass), 1);

        // Strict order violation
        mon_bus = 16'h0000;
        tick(5);
        do_start(3'd2, 24'd0, 1'b1);
        mon_bus = 16'hAB61;
        tick(3);
        check("order_fail_early", 32'(fail), 0);
        tick(1);
        check("order_fail",  32'(fail), 1);
        check("order_code",  32'(fail_code), 2);
        check("order_stage", 32'(stage_idx), 0);
        check("order_busy",  32'(busy), 0);

        // Non-strict: out-of-order value ignored
        mon_bus = 16'h0000;
        tick(5);
        do_start(3'd2, 24'd0, 1'b0);
        mon_bus = 16'hAB61;
        tick(6);
        check("loose_fail",  32'(fail), 0);
        check("loose_busy",  32'(busy), 1);
        check("loose_stage", 32'(stage_idx), 0);
        mon_bus = 16'hAB60;
        tick(4);
        check("loose_s1", 32'(stage_idx), 1);
        mon_bus = 16'hAB61;
        tick(4);
        check("loose_pass", 32'(pass), 1);

        // Timeout with no activity
        mon_bus = 16'h0000;
        tick(5);
        do_start(3'd2, 24'd100, 1'b0);
        tick(99);
        check("tmo_fail_early", 32'(fail), 0);
        tick(1);
        check("tmo_fail",  32'(fail), 1);
        check("tmo_code",  32'(fail_code), 1);
        check("tmo_stage", 32'(stage_idx), 0);

        // Match on the expiry cycle wins and restarts the budget
        do_start(3'd2, 24'd100, 1'b0);
        check("tmo2_cleared", 32'(fail), 0);
        tick(96);
        mon_bus = 16'hAB60;
        tick(3);
        check("tmo2_pre_fail",  32'(fail), 0);
        check("tmo2_pre_stage", 32'(stage_idx), 0);
        tick(1);
        check("tmo2_stage", 32'(stage_idx), 1);
        check("tmo2_fail",  32'(fail), 0);
        tick(99);
        check("tmo2_late_early", 32'(fail), 0);
        tick(1);
        check("tmo2_late_fail", 32'(fail), 1);
        check("tmo2_late_code", 32'(fail_code), 1);

        // Zero stages passes immediately
        do_start(3'd0, 24'd0, 1'b0);
        check("zero_pass", 32'(pass), 1);
        check("zero_fail", 32'(fail), 0);
        check("zero_code", 32'(fail_code), 0);
        check("zero_busy", 32'(busy), 0);

        // Reset mid-run clears outputs and the checkpoint table
        mon_bus = 16'h0000;
        tick(5);
        do_start(3'd2, 24'd0, 1'b0);
        mon_bus = 16'hAB60;
        tick(4);
        check("mid_stage", 32'(stage_idx), 1);
        resetb = 1'b0;
        #1;
        check("arst_stage",  32'(stage_idx), 0);
        check("arst_busy",   32'(busy), 0);
        check("arst_strobe", 32'(stage_strobe), 0);
        check("arst_pass",   32'(pass), 0);
        tick(1);
        resetb = 1'b1;
        tick(5);
        do_start(3'd2, 24'd0, 1'b0);
        mon_bus = 16'h1234;
        tick(5);
        mon_bus = 16'hAB60;
        tick(6);
        check("cleared_stage",  32'(stage_idx), 0);
        check("cleared_busy",   32'(busy), 1);
        check("cleared_strobe", 32'(stage_strobe), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
